// File: rtl/cache_2way.sv
// cache_2way: 2-way set-associative, write-back, write-allocate data cache.
// Holds 2**IDX_W sets of two 128-bit (4-word) blocks with one LRU bit per set.
// Hits are resolved combinationally in IDLE. A miss optionally writes back a
// dirty victim (WBACK), then refills it (ALLOC) and re-evaluates as a hit.
// Ports:
//   clk, proc_reset                  clock, async active-high reset
//   proc_read/proc_write/proc_addr/proc_wdata   processor request
//   proc_stall/proc_rdata            request status / read data
//   mem_read/mem_write/mem_addr/mem_wdata       block refill / write-back request
//   mem_rdata/mem_ready              refill block / one-cycle completion pulse
module cache_2way #(
  parameter int IDX_W  = 3,
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [31:0]       proc_wdata,
  output logic              proc_stall,
  output logic [31:0]       proc_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic [127:0]      mem_rdata,
  input  logic              mem_ready
);

  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam int NSETS = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, WBACK, ALLOC} state_t;

  state_t state_q, state_d;

  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  assign off = proc_addr[1:0];
  assign idx = proc_addr[IDX_W+1:2];
  assign tag = proc_addr[ADDR_W-1:IDX_W+2];

  // Tag and data arrays carry no reset; the valid bits gate their use.
  logic [TAG_W-1:0] tag_q  [2][NSETS];
  logic [127:0]     data_q [2][NSETS];

  logic [1:0][NSETS-1:0] valid_q, valid_d;
  logic [1:0][NSETS-1:0] dirty_q, dirty_d;
  logic [NSETS-1:0]      lru_q, lru_d;
  logic                  victim_q, victim_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;

  logic       req;
  logic [1:0] way_hit;
  logic       hit;
  logic       hit_way;
  logic       victim_sel;
  logic       fill_we;
  logic       word_we;
  logic [127:0] hit_block;

  assign req = proc_read ^ proc_write;

  always_comb begin
    way_hit = '0;
    for (int unsigned w = 0; w < 2; w++) begin
      way_hit[w] = valid_q[w][idx] && (tag_q[w][idx] == tag);
    end
  end

  assign hit       = |way_hit;
  assign hit_way   = way_hit[1];
  assign hit_block = data_q[hit_way][idx];
  assign proc_rdata = hit_block[{off, 5'b0} +: 32];

  // Prefer an empty way (way 0 first) before evicting the LRU way.
  assign victim_sel = !valid_q[0][idx] ? 1'b0 :
                      !valid_q[1][idx] ? 1'b1 : lru_q[idx];

  assign proc_stall = (state_q != IDLE) || (req && !hit);

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = (state_q == WBACK) ? {tag_q[victim_q][idx], idx} : {tag, idx};
  assign mem_wdata = data_q[victim_q][idx];

  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    valid_d  = valid_q;
    dirty_d  = dirty_q;
    lru_d    = lru_q;
    fill_we  = 1'b0;
    word_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            lru_d[idx] = ~hit_way;
            if (proc_write) begin
              word_we                = 1'b1;
              dirty_d[hit_way][idx]  = 1'b1;
            end
          end else begin
            victim_d = victim_sel;
            state_d  = (valid_q[victim_sel][idx] && dirty_q[victim_sel][idx]) ? WBACK : ALLOC;
          end
        end
      end
      WBACK: if (mem_ready) state_d = ALLOC;
      ALLOC: begin
        if (mem_ready) begin
          // The refilled request is replayed in IDLE as a hit, so a pending
          // write merges into the freshly filled block on the next edge.
          state_d                 = IDLE;
          fill_we                 = !proc_reset;
          valid_d[victim_q][idx]  = 1'b1;
          dirty_d[victim_q][idx]  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    mem_read_d  = (state_d == ALLOC);
    mem_write_d = (state_d == WBACK);
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q     <= IDLE;
      victim_q    <= 1'b0;
      valid_q     <= '0;
      dirty_q     <= '0;
      lru_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      victim_q    <= victim_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      lru_q       <= lru_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[victim_q][idx]  <= tag;
      data_q[victim_q][idx] <= mem_rdata;
    end
    if (word_we) begin
      data_q[hit_way][idx][{off, 5'b0} +: 32] <= proc_wdata;
    end
  end

endmodule

// File: tb/tb_cache_2way.sv
// tb_cache_2way: directed + randomized bench for cache_2way. A flat word
// memory model (processor view plus backing store) and a per-set tag/LRU
// table predict hits, victims, write-backs, stall length and read data.
module tb_cache_2way;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int checks   = 0;
  int failures = 0;

  cache_2way #(.IDX_W(3), .ADDR_W(30)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_stall(proc_stall), .proc_rdata(proc_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Reference state
  bit          m_valid [8][2];
  bit          m_dirty [8][2];
  int unsigned m_tag   [8][2];
  bit          m_lru   [8];
  logic [31:0] mem_w  [int unsigned];
  logic [31:0] shadow [int unsigned];

  function automatic logic [31:0] mem_rd(int unsigned a);
    if (mem_w.exists(a)) return mem_w[a];
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  function automatic logic [31:0] view_rd(int unsigned a);
    if (shadow.exists(a)) return shadow[a];
    return mem_rd(a);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = 0;
      end
    end
    shadow.delete();
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One processor access; the bench acts as memory with fixed latency.
  task automatic access(input bit rd, input bit wr, input int unsigned addr,
                        input logic [31:0] wd, input int unsigned lat);
    int unsigned idx, tg, blk, vblk, exp_cyc, cyc, wbc, rdc;
    int          hw;
    bit          req, miss, wb, vic;
    logic [127:0] exp_wb;
    idx = (addr >> 2) & 7;
    tg  = addr >> 5;
    blk = addr >> 2;
    req = rd ^ wr;
    hw  = -1;
    for (int w = 0; w < 2; w++)
      if (m_valid[idx][w] && m_tag[idx][w] == tg) hw = w;
    miss = req && (hw < 0);
    vic  = !m_valid[idx][0] ? 1'b0 : !m_valid[idx][1] ? 1'b1 : m_lru[idx];
    wb   = miss && m_valid[idx][vic] && m_dirty[idx][vic];
    vblk = m_tag[idx][vic] * 8 + idx;
    for (int k = 0; k < 4; k++) exp_wb[32*k +: 32] = view_rd(vblk * 4 + k);
    exp_cyc = miss ? (1 + lat + (wb ? lat : 0)) : 0;

    proc_read  = rd;
    proc_write = wr;
    proc_addr  = addr[29:0];
    proc_wdata = wd;
    cyc = 0; wbc = 0; rdc = 0;
    while (cyc < 200) begin
      #1;
      if (!proc_stall) break;
      cyc++;
      chk("mem_excl", {1'b0, mem_read & mem_write}, 0);
      if (mem_write) begin
        wbc++;
        if (wbc == 1) begin
          chk("wb_addr", mem_addr, vblk);
          chk("wb_data", mem_wdata, exp_wb);
        end
        if (wbc == lat) begin
          for (int k = 0; k < 4; k++) mem_w[vblk * 4 + k] = mem_wdata[32*k +: 32];
          mem_ready = 1'b1;
        end
      end else if (mem_read) begin
        rdc++;
        if (rdc == 1) chk("rd_addr", mem_addr, blk);
        if (rdc == lat) begin
          for (int k = 0; k < 4; k++) mem_rdata[32*k +: 32] = mem_rd(blk * 4 + k);
          mem_ready = 1'b1;
        end
      end
      @(posedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
    end
    chk("stall_drop", {1'b0, proc_stall}, 0);
    chk("stall_cycles", cyc, exp_cyc);
    chk("wb_cycles", wbc, wb ? lat : 0);
    chk("rd_cycles", rdc, miss ? lat : 0);
    chk("idle_mem", {mem_read, mem_write}, 0);
    if (rd && !wr) chk("rdata", proc_rdata, view_rd(addr));
    @(posedge clk);
    @(negedge clk);
    proc_read  = 1'b0;
    proc_write = 1'b0;
    if (req) begin
      int w;
      w = miss ? int'(vic) : hw;
      if (miss) begin
        m_valid[idx][w] = 1'b1;
        m_tag[idx][w]   = tg;
        m_dirty[idx][w] = 1'b0;
      end
      m_lru[idx] = (w == 0);
      if (wr) begin
        m_dirty[idx][w] = 1'b1;
        shadow[addr]    = wd;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned xaddr;
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    model_reset();
    #1;
    chk("rst_mem_read", {1'b0, mem_read}, 0);
    chk("rst_mem_write", {1'b0, mem_write}, 0);
    chk("rst_stall", {1'b0, proc_stall}, 0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    proc_reset = 1'b0;

    // Cold read miss with 3-cycle refill of a recognisable block
    mem_w[4] = 32'h1111_1111; mem_w[5] = 32'h2222_2222;
    mem_w[6] = 32'h3333_3333; mem_w[7] = 32'h4444_4444;
    access(1, 0, 32'h4, '0, 3);
    // Write hit then read back
    access(0, 1, 32'h5, 32'hDEAD_BEEF, 1);
    access(1, 0, 32'h5, '0, 1);
    // Second way of set 1, touch A, clean victim B replaced by C
    access(1, 0, 32'h24, '0, 2);
    access(1, 0, 32'h4, '0, 2);
    access(1, 0, 32'h44, '0, 2);
    // Touch C so dirty A becomes LRU, miss D forces a write-back
    access(1, 0, 32'h44, '0, 2);
    access(1, 0, 32'h64, '0, 2);
    access(1, 0, 32'h5, '0, 2);
    // Read and write together: no effect
    access(1, 1, 32'h5, 32'h1234_5678, 1);
    access(1, 0, 32'h5, '0, 1);

    // Randomized traffic over a small address footprint
    for (int n = 0; n < 300; n++) begin
      int unsigned op, a;
      op = $urandom % 8;
      a  = (($urandom % 4) << 5) | (($urandom % 8) << 2) | ($urandom % 4);
      if (op == 0)      access(0, 0, a, $urandom, 1);
      else if (op == 1) access(1, 1, a, $urandom, 1);
      else if (op < 5)  access(0, 1, a, $urandom, $urandom_range(1, 3));
      else              access(1, 0, a, $urandom, $urandom_range(1, 3));
      if ($urandom % 6 == 0) begin
        mem_ready = 1'b1;
        #1;
        chk("stray_ready_stall", {1'b0, proc_stall}, 0);
        @(posedge clk); @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("stray_ready_mem", {mem_read, mem_write}, 0);
      end
    end

    // Reset in the middle of a refill
    xaddr = (9 << 5) | (2 << 2) | 1;
    proc_read = 1'b1;
    proc_addr = xaddr[29:0];
    #1;
    chk("abort_miss_stall", {1'b0, proc_stall}, 1);
    @(posedge clk); @(negedge clk); #1;
    chk("abort_alloc_read", {1'b0, mem_read}, 1);
    @(posedge clk); @(negedge clk); #1;
    proc_reset = 1'b1;
    #1;
    chk("abort_read_drop", {1'b0, mem_read}, 0);
    chk("abort_write_low", {1'b0, mem_write}, 0);
    @(posedge clk); @(negedge clk);
    proc_reset = 1'b0;
    proc_read  = 1'b0;
    model_reset();
    access(1, 0, xaddr, '0, 2);
    access(1, 0, 32'h5, '0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
